branch_ctrl: RTL and testbench

//  Sequences branch resolution in the ID stage around the combinational branch-condition unit.

---
 rtl/branch_pkg.sv | 32 +++
 rtl/branch_ctrl_if.sv | 48 ++++
 rtl/branch_hazard_detect.sv | 46 ++++
 rtl/branch_ctrl.sv | 117 +++++++++++
 tb/tb_branch_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types for the ID-stage branch controller:
// branch type codes, FSM state encodings and stall-count width.
package branch_pkg;

    localparam int NEED_W = 2;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_GTZ  = 3'd3,
        BR_LTZ  = 3'd4,
        BR_GEZ  = 3'd5,
        BR_LEZ  = 3'd6,
        BR_RSV  = 3'd7
    } br_type_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESOLVE = 2'd2
    } state_e;

    function automatic logic is_branch(input logic [2:0] t);
        return (t != BR_NONE) && (t != BR_RSV);
    endfunction

    function automatic logic uses_rt(input logic [2:0] t);
        return (t == BR_EQ) || (t == BR_NE);
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle between the ID stage, hazard sources, branch-condition unit
// and the PC mux as seen by branch_ctrl.
interface branch_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int ADDR_W = 32,
    parameter int STAT_W = 32
);
    logic              id_valid;
    logic [2:0]        id_brType;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [ADDR_W-1:0] id_target;
    logic              ex_regWrite;
    logic              ex_memRead;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_regWrite;
    logic              mem_memRead;
    logic [REG_AW-1:0] mem_rd;
    logic              branchAvail;
    logic              stall_if_id;
    logic              flush_if_id;
    logic              pc_sel;
    logic [ADDR_W-1:0] pc_target;
    logic              fwd_a;
    logic              fwd_b;
    logic [STAT_W-1:0] st_total;
    logic [STAT_W-1:0] st_taken;
    logic [STAT_W-1:0] st_stall;

    modport master (
        output id_valid, id_brType, id_rs, id_rt, id_target,
        output ex_regWrite, ex_memRead, ex_rd,
        output mem_regWrite, mem_memRead, mem_rd,
        output branchAvail,
        input  stall_if_id, flush_if_id, pc_sel, pc_target,
        input  fwd_a, fwd_b, st_total, st_taken, st_stall
    );

    modport slave (
        input  id_valid, id_brType, id_rs, id_rt, id_target,
        input  ex_regWrite, ex_memRead, ex_rd,
        input  mem_regWrite, mem_memRead, mem_rd,
        input  branchAvail,
        output stall_if_id, flush_if_id, pc_sel, pc_target,
        output fwd_a, fwd_b, st_total, st_taken, st_stall
    );

endinterface

// File: rtl/branch_hazard_detect.sv
// Combinational RAW check on branch operands: stall length needed
// before resolution and EX/MEM forwarding selects.
module branch_hazard_detect
    import branch_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [2:0]        br_type,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              ex_wr,
    input  logic              ex_ld,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              mem_wr,
    input  logic              mem_ld,
    input  logic [REG_AW-1:0] mem_rd,
    output logic [NEED_W-1:0] need,
    output logic              fwd_a,
    output logic              fwd_b
);

    logic ex_ok, mem_ok;
    logic ex_a, ex_b, mem_a, mem_b;
    logic [NEED_W-1:0] need_a, need_b;

    assign ex_ok  = ex_wr && (ex_rd != '0);
    assign mem_ok = mem_wr && (mem_rd != '0);

    assign ex_a  = ex_ok && (ex_rd == rs);
    assign ex_b  = ex_ok && (ex_rd == rt);
    assign mem_a = mem_ok && (mem_rd == rs);
    assign mem_b = mem_ok && (mem_rd == rt);

    // An EX load is two cycles from usable data; anything else one.
    assign need_a = ex_a ? (ex_ld ? 2'd2 : 2'd1)
                  : ((mem_a && mem_ld) ? 2'd1 : 2'd0);

    assign need_b = !uses_rt(br_type) ? 2'd0
                  : ex_b ? (ex_ld ? 2'd2 : 2'd1)
                  : ((mem_b && mem_ld) ? 2'd1 : 2'd0);

    assign need  = (need_a > need_b) ? need_a : need_b;
    assign fwd_a = mem_a && !mem_ld;
    assign fwd_b = mem_b && !mem_ld;

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stall, forward, redirect and flush.
// Define BRANCH_STATS_EN to build the saturating statistics counters.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int ADDR_W = 32,
    parameter int STAT_W = 32
) (
    input logic          clk,
    input logic          rst,
    branch_ctrl_if.slave bus
);

    state_e            state;
    logic [NEED_W-1:0] cnt;
    logic [NEED_W-1:0] need;
    logic              is_br;
    logic              hz_a, hz_b;
    logic              stall, resolve, taken;

    branch_hazard_detect #(.REG_AW(REG_AW)) u_hz (
        .br_type (bus.id_brType),
        .rs      (bus.id_rs),
        .rt      (bus.id_rt),
        .ex_wr   (bus.ex_regWrite),
        .ex_ld   (bus.ex_memRead),
        .ex_rd   (bus.ex_rd),
        .mem_wr  (bus.mem_regWrite),
        .mem_ld  (bus.mem_memRead),
        .mem_rd  (bus.mem_rd),
        .need    (need),
        .fwd_a   (hz_a),
        .fwd_b   (hz_b)
    );

    assign is_br = bus.id_valid && is_branch(bus.id_brType);

    always_comb begin
        stall   = 1'b0;
        resolve = 1'b0;
        if (!rst) begin
            unique case (state)
                S_IDLE: begin
                    stall   = is_br && (need != '0);
                    resolve = is_br && (need == '0);
                end
                S_WAIT:    stall   = 1'b1;
                S_RESOLVE: resolve = is_br;
                default: ;
            endcase
        end
    end

    assign taken = resolve && bus.branchAvail;

    assign bus.stall_if_id = stall;
    assign bus.pc_sel      = taken;
    assign bus.flush_if_id = taken;
    assign bus.pc_target   = taken ? bus.id_target
                                   : {ADDR_W{1'b0}};
    assign bus.fwd_a       = !rst && hz_a;
    assign bus.fwd_b       = !rst && hz_b;

    // Stall length is latched in IDLE; WAIT only counts it down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (is_br && (need != '0)) begin
                        cnt   <= need;
                        state <= (need == 2'd1) ? S_RESOLVE
                                                : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 2'd2)
                        state <= S_RESOLVE;
                end
                S_RESOLVE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] n_total, n_taken, n_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            n_total <= '0;
            n_taken <= '0;
            n_stall <= '0;
        end else begin
            if (resolve && (n_total != '1))
                n_total <= n_total + 1'b1;
            if (taken && (n_taken != '1))
                n_taken <= n_taken + 1'b1;
            if (stall && (n_stall != '1))
                n_stall <= n_stall + 1'b1;
        end
    end

    assign bus.st_total = rst ? {STAT_W{1'b0}} : n_total;
    assign bus.st_taken = rst ? {STAT_W{1'b0}} : n_taken;
    assign bus.st_stall = rst ? {STAT_W{1'b0}} : n_stall;
`else
    assign bus.st_total = {STAT_W{1'b0}};
    assign bus.st_taken = {STAT_W{1'b0}};
    assign bus.st_stall = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: stall lengths, forwarding,
// redirect/flush, reset abandonment and optional statistics.
module tb_branch_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    branch_ctrl_if #(.REG_AW(5), .ADDR_W(32), .STAT_W(32)) bus ();

    branch_ctrl #(.REG_AW(5), .ADDR_W(32), .STAT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic [2:0] t,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [31:0] tgt, input logic av);
        bus.id_valid    = v;
        bus.id_brType   = t;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_target   = tgt;
        bus.branchAvail = av;
    endtask

    task automatic ex_set(input logic wr, input logic ld,
                          input logic [4:0] rd);
        bus.ex_regWrite = wr;
        bus.ex_memRead  = ld;
        bus.ex_rd       = rd;
    endtask

    task automatic mem_set(input logic wr, input logic ld,
                           input logic [4:0] rd);
        bus.mem_regWrite = wr;
        bus.mem_memRead  = ld;
        bus.mem_rd       = rd;
    endtask

    task automatic quiet();
        id_set(1'b0, 3'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        ex_set(1'b0, 1'b0, 5'd0);
        mem_set(1'b0, 1'b0, 5'd0);
    endtask

    // ctl = {stall, flush, pc_sel, fwd_a, fwd_b}
    task automatic expect_out(input string tag,
                              input logic [4:0] ctl,
                              input logic [31:0] tgt);
        logic [4:0] got;
        #1;
        got = {bus.stall_if_id, bus.flush_if_id, bus.pc_sel,
               bus.fwd_a, bus.fwd_b};
        chk({tag, "_ctl"}, 64'(got), 64'(ctl));
        chk({tag, "_pc"}, 64'(bus.pc_target), 64'(tgt));
    endtask

    task automatic expect_st(input string tag, input int tot,
                             input int tak, input int stl);
        chk({tag, "_total"}, 64'(bus.st_total), 64'(tot));
        chk({tag, "_taken"}, 64'(bus.st_taken), 64'(tak));
        chk({tag, "_stall"}, 64'(bus.st_stall), 64'(stl));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        quiet();

        // reset forces everything low even with a live hazard
        id_set(1'b1, 3'd1, 5'd5, 5'd6, 32'h44, 1'b1);
        ex_set(1'b1, 1'b1, 5'd6);
        mem_set(1'b1, 1'b0, 5'd5);
        step();
        step();
        expect_out("rst", 5'b00000, 32'h0);
        expect_st("rst", 0, 0, 0);
        rst = 1'b0;
        quiet();
        step();

        // 1: beq, no hazard, taken in the same cycle
        id_set(1'b1, 3'd1, 5'd1, 5'd2, 32'h40, 1'b1);
        expect_out("t1", 5'b01100, 32'h40);
        step();
        quiet();
        expect_out("t1_idle", 5'b00000, 32'h0);
        step();

        // 2: EX ALU rd=5 feeding beq rs=5 -> one stall, then fwd_a
        id_set(1'b1, 3'd1, 5'd5, 5'd6, 32'h80, 1'b1);
        ex_set(1'b1, 1'b0, 5'd5);
        expect_out("t2_stall", 5'b10000, 32'h0);
        step();
        ex_set(1'b0, 1'b0, 5'd0);
        mem_set(1'b1, 1'b0, 5'd5);
        expect_out("t2_res", 5'b01110, 32'h80);
        step();
        quiet();
        expect_out("t2_idle", 5'b00000, 32'h0);

        // 3: EX load rd=8 feeding bgtz rs=8 -> two stalls
        id_set(1'b1, 3'd3, 5'd8, 5'd0, 32'h100, 1'b1);
        ex_set(1'b1, 1'b1, 5'd8);
        expect_out("t3_s1", 5'b10000, 32'h0);
        step();
        ex_set(1'b0, 1'b0, 5'd0);
        mem_set(1'b1, 1'b1, 5'd8);
        expect_out("t3_s2", 5'b10000, 32'h0);
        step();
        mem_set(1'b0, 1'b0, 5'd0);
        expect_out("t3_res", 5'b01100, 32'h100);
        step();
        quiet();
        expect_out("t3_idle", 5'b00000, 32'h0);

        // 4a: rd=0 never creates a hazard or a forward
        id_set(1'b1, 3'd1, 5'd0, 5'd0, 32'h200, 1'b1);
        ex_set(1'b1, 1'b1, 5'd0);
        mem_set(1'b1, 1'b0, 5'd0);
        expect_out("t4_rd0", 5'b01100, 32'h200);
        step();
        quiet();

        // 4b: bltz ignores rt
        id_set(1'b1, 3'd4, 5'd3, 5'd9, 32'h204, 1'b1);
        ex_set(1'b1, 1'b1, 5'd9);
        expect_out("t4_rt", 5'b01100, 32'h204);
        step();

        // 4c: beq does use rt; stall length fixed at IDLE
        id_set(1'b1, 3'd1, 5'd3, 5'd9, 32'h208, 1'b0);
        expect_out("t4c_s1", 5'b10000, 32'h0);
        step();
        ex_set(1'b0, 1'b0, 5'd0);
        expect_out("t4c_s2", 5'b10000, 32'h0);
        step();
        mem_set(1'b1, 1'b0, 5'd9);
        expect_out("t4c_res", 5'b00001, 32'h0);
        step();
        quiet();

        // type 7 and id_valid=0 are not branches
        id_set(1'b1, 3'd7, 5'd4, 5'd4, 32'h20c, 1'b1);
        ex_set(1'b1, 1'b0, 5'd4);
        expect_out("t_typ7", 5'b00000, 32'h0);
        id_set(1'b0, 3'd1, 5'd4, 5'd4, 32'h20c, 1'b1);
        expect_out("t_novld", 5'b00000, 32'h0);
        step();
        quiet();

        // 5: reset while in WAIT abandons the branch
        id_set(1'b1, 3'd3, 5'd8, 5'd0, 32'h300, 1'b1);
        ex_set(1'b1, 1'b1, 5'd8);
        expect_out("t5_s1", 5'b10000, 32'h0);
        step();
        rst = 1'b1;
        expect_out("t5_rst", 5'b00000, 32'h0);
        step();
        rst = 1'b0;
        quiet();
        id_set(1'b1, 3'd1, 5'd4, 5'd1, 32'h310, 1'b1);
        ex_set(1'b1, 1'b0, 5'd4);
        expect_out("t5_new", 5'b10000, 32'h0);
        step();
        ex_set(1'b0, 1'b0, 5'd0);
        expect_out("t5_res", 5'b01100, 32'h310);
        step();
        quiet();

        // 6: stats over 3 branches (2 taken, one 2-cycle stall)
        rst = 1'b1;
        step();
        rst = 1'b0;
        id_set(1'b1, 3'd1, 5'd1, 5'd2, 32'h400, 1'b1);
        step();
        id_set(1'b1, 3'd2, 5'd1, 5'd2, 32'h404, 1'b0);
        step();
        id_set(1'b1, 3'd5, 5'd7, 5'd0, 32'h408, 1'b1);
        ex_set(1'b1, 1'b1, 5'd7);
        step();
        ex_set(1'b0, 1'b0, 5'd0);
        step();
        expect_out("t6_res", 5'b01100, 32'h408);
        step();
        quiet();
        #1;
`ifdef BRANCH_STATS_EN
        expect_st("t6", 3, 2, 2);
`else
        expect_st("t6", 0, 0, 0);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
